spi_memory_param: RTL and testbench
===================================

SPI_MEMORY_PARAM -- requirements
Module: spi_memory_param

Interface
REQ-001 Parameter ADDR_W, default 7: address width; DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8: word width and data-frame length in bits.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flops per SPI input, legal values >= 2.
REQ-004 clk  input  1  FPGA system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 sclk_pin  input  1  SPI clock, asynchronous to clk.
REQ-007 cs_pin  input  1  SPI chip select, active-low.
REQ-008 mosi_pin  input  1  master-out slave-in serial data.
REQ-009 miso_pin  output  1  master-in slave-out serial data.
REQ-010 miso_oe  output  1  high while miso_pin carries valid read data; drives the board tristate.
REQ-011 fault_pin  input  1  fault-injection request, quasi-static.
REQ-012 leds  output  4  debug: [2:0] FSM state code, [3] fault active.

Function
REQ-013 Input conditioning:
- Each of sclk, cs and mosi passes through SYNC_STAGES flops, then one edge register.
- sclk rise, sclk fall and cs fall/rise are each one-clk pulses, asserted SYNC_STAGES+1 clk after the pin transition.
REQ-014 SPI mode 0: mosi sampled on sclk-rise pulse; miso updated on sclk-fall pulse; all fields MSB first.
REQ-015 Frame format:
- Command of ADDR_W+1 bits: address[ADDR_W-1:0], then R/W bit (1 = read, 0 = write).
- Followed by any number of DATA_W-bit data words (burst).
REQ-016 State codes: IDLE 0, CMD 1, RD_LOAD 2, RD_SHIFT 3, WR_SHIFT 4, WR_COMMIT 5; codes 6-7 unused and recover to IDLE.
REQ-017 IDLE -> CMD on cs-fall pulse; bit counter cleared.
REQ-018 CMD: shift ADDR_W+1 bits; on last bit latch address; -> RD_LOAD if R/W = 1, else -> WR_SHIFT.
REQ-019 RD_LOAD (exactly one clk):
- Load memory[addr] into shift register.
- Drive miso_pin = word MSB; set miso_oe = 1.
- addr <= addr+1; -> RD_SHIFT.
REQ-020 RD_SHIFT:
- Each sclk-fall shifts the next bit onto miso_pin.
- On the DATA_W-th sclk-rise of the word -> RD_LOAD (burst continues).
REQ-021 WR_SHIFT: shift mosi in on each sclk-rise; after DATA_W bits -> WR_COMMIT.
REQ-022 WR_COMMIT (exactly one clk): memory[addr] <= shift register; addr <= addr+1; -> WR_SHIFT.
REQ-023 Address increment is modulo DEPTH: DEPTH-1 wraps to 0.
REQ-024 cs-rise pulse in any state:
- -> IDLE on next clk; miso_oe = 0.
- Partial write word (< DATA_W bits) discarded with no memory write.
- Words already committed remain.
REQ-025 cs-rise coincident with WR_COMMIT: commit completes that cycle, then -> IDLE.
REQ-026 sclk edges and mosi while cs high are ignored; memory and state unchanged.
REQ-027 miso_oe = 0 implies miso_pin = 0.
REQ-028 Memory: DEPTH x DATA_W, synchronous write, single port.

Reset
REQ-029 rst_n low at a clk rising edge sets:
- state IDLE; bit counter, addr and shift register to 0.
- miso_pin = 0, miso_oe = 0, leds = 0.
- Synchroniser flops to idle values: sclk 0, cs 1, mosi 0.
REQ-030 Memory contents are not reset and are retained across reset.
REQ-031 Reset mid-transaction aborts it; with cs held low across release, no frame starts until a new cs falling edge.

Configuration
REQ-032 Macro FAULT_INJECT_EN.
- Defined: while fault_pin = 1, WR_COMMIT performs no memory write (write enable stuck at 0); address still increments; leds[3] = fault_pin; all else unchanged.
- Undefined: fault_pin ignored; leds[3] = 0.

Verification (ADDR_W=7, DATA_W=8)
REQ-033 Write 0xA5 to 0x12, then read 0x12 -> miso returns 0xA5; miso_oe high only during data phase.
REQ-034 Burst write at 0x7F of 0x11, 0x22 -> burst read from 0x7F returns 0x11 then 0x22, with mem[0x00] = 0x22 (wrap).
REQ-035 mem[0x05] = 0x3C; write command to 0x05, 5 data bits, cs high -> read 0x05 returns 0x3C; leds = 0 after abort.
REQ-036 rst_n low 1 clk mid-read of 0x12 -> next clk leds = 0, miso_oe = 0; later read of 0x12 returns 0xA5.
REQ-037 FAULT_INJECT_EN defined, mem[0x20] = 0x00, fault_pin = 1, write 0xFF -> read 0x00.
- Repeat with fault_pin = 0 -> read 0xFF.
- Macro undefined -> read 0xFF regardless of fault_pin.
REQ-038 16 sclk toggles with cs high -> leds stay 0; no memory change.

Source files
------------

// File: rtl/spi_memory_param.sv
// SPI mode-0 slave fronting a DEPTH x DATA_W RAM with burst read/write and address auto-increment (optional FAULT_INJECT_EN).
// Latency: SPI pins reach the FSM SYNC_STAGES+1 clk after a pin transition; each read word loads one clk after its command/word ends.
// Backpressure: none; the SPI master paces every transfer, and a cs rise aborts the frame (a partial write word is dropped).
module spi_memory_param #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    input  logic       fault_pin,
    output logic [3:0] leds
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int CNT_MAX = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_RD_LOAD   = 3'd2,
        ST_RD_SHIFT  = 3'd3,
        ST_WR_SHIFT  = 3'd4,
        ST_WR_COMMIT = 3'd5
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                sclk_d;
    logic                cs_d;
    logic                sclk_rise;
    logic                sclk_fall;
    logic                cs_fall;
    logic                cs_rise;
    logic                mosi_bit;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic                armed;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   sh_next;
    logic [DATA_W-1:0]   rd_word;
    logic                fault_active;
    logic                mem_we;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
    assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_d;
    assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_d & armed;
    assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

    // A cs held low across reset release would look like a fall once the
    // synchronisers flush; only arm frame start after cs is seen high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else if (flush_cnt != FLUSH_W'(SYNC_STAGES + 1)) begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
        end else if (cs_d) begin
            armed <= 1'b1;
        end
    end

`ifdef FAULT_INJECT_EN
    logic fault_q;
    always_ff @(posedge clk) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_pin;
    end
    assign fault_active = fault_q;
`else
    logic unused_fault;
    assign unused_fault = fault_pin;
    assign fault_active = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (cs_fall) next_state = ST_CMD;
            ST_CMD:       if (sclk_rise && bit_cnt == CNT_W'(ADDR_W))
                              next_state = mosi_bit ? ST_RD_LOAD : ST_WR_SHIFT;
            ST_RD_LOAD:   next_state = ST_RD_SHIFT;
            ST_RD_SHIFT:  if (sclk_rise && bit_cnt == CNT_W'(DATA_W - 1))
                              next_state = ST_RD_LOAD;
            ST_WR_SHIFT:  if (sclk_rise && bit_cnt == CNT_W'(DATA_W - 1))
                              next_state = ST_WR_COMMIT;
            ST_WR_COMMIT: next_state = ST_WR_SHIFT;
            default:      next_state = ST_IDLE;
        endcase
        if (cs_rise) next_state = ST_IDLE;
    end

    assign rd_word = mem[addr];
    assign sh_next = shreg << 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            addr     <= '0;
            shreg    <= '0;
            miso_pin <= 1'b0;
            miso_oe  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_cnt  <= '0;
                    miso_pin <= 1'b0;
                    miso_oe  <= 1'b0;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        if (bit_cnt == CNT_W'(ADDR_W)) begin
                            bit_cnt <= '0;
                        end else begin
                            addr    <= ADDR_W'({addr, mosi_bit});
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RD_LOAD: begin
                    shreg    <= rd_word;
                    miso_pin <= rd_word[DATA_W-1];
                    miso_oe  <= 1'b1;
                    addr     <= addr + ADDR_W'(1);
                    bit_cnt  <= '0;
                end
                ST_RD_SHIFT: begin
                    // The first fall after a load belongs to the previous word's last bit.
                    if (sclk_fall && bit_cnt != '0) begin
                        shreg    <= sh_next;
                        miso_pin <= sh_next[DATA_W-1];
                    end
                    if (sclk_rise) bit_cnt <= bit_cnt + CNT_W'(1);
                end
                ST_WR_SHIFT: begin
                    if (sclk_rise) begin
                        shreg   <= DATA_W'({shreg, mosi_bit});
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_WR_COMMIT: begin
                    addr    <= addr + ADDR_W'(1);
                    bit_cnt <= '0;
                end
                default: begin
                    bit_cnt  <= '0;
                    miso_pin <= 1'b0;
                    miso_oe  <= 1'b0;
                end
            endcase
            if (cs_rise) begin
                bit_cnt  <= '0;
                miso_pin <= 1'b0;
                miso_oe  <= 1'b0;
            end
        end
    end

    // Commit completes even when cs rises in the same cycle.
    assign mem_we = rst_n && (state == ST_WR_COMMIT) && !fault_active;

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= shreg;
    end

    assign leds = {fault_active, state};

endmodule

// File: tb/tb_spi_memory_param.sv
module tb_spi_memory_param;
    localparam int AW   = 7;
    localparam int DW   = 8;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk_pin = 1'b0;
    logic       cs_pin = 1'b1;
    logic       mosi_pin = 1'b0;
    logic       fault_pin = 1'b0;
    logic       miso_pin;
    logic       miso_oe;
    logic [3:0] leds;

    always #5 clk = ~clk;

    spi_memory_param #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
        .mosi_pin(mosi_pin), .miso_pin(miso_pin), .miso_oe(miso_oe),
        .fault_pin(fault_pin), .leds(leds)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] model [128];
    bit         known [128];
    bit         fault_blocks;

    typedef struct {
        bit              wr;
        logic [6:0]      addr;
        int              n;
        logic [3:0][7:0] dat;   // write data, or expected read data
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r, output logic oe);
        mosi_pin = b;
        clks(HALF);
        r  = miso_pin;
        oe = miso_oe;
        sclk_pin = 1'b1;
        clks(HALF);
        sclk_pin = 1'b0;
    endtask

    task automatic spi_cmd(input logic [6:0] a, input logic rw);
        logic r, oe;
        int   oe_bad;
        oe_bad = 0;
        cs_pin = 1'b0;
        clks(HALF);
        check("cmd_state", {28'd0, leds}, 32'h1);
        for (int i = AW - 1; i >= 0; i--) begin
            bit_xfer(a[i], r, oe);
            if (oe) oe_bad++;
        end
        bit_xfer(rw, r, oe);
        if (oe) oe_bad++;
        check("cmd_oe_low", oe_bad, 0);
    endtask

    task automatic spi_end();
        mosi_pin = 1'b0;
        clks(HALF);
        cs_pin = 1'b1;
        clks(3 * HALF);
    endtask

    task automatic spi_write(input logic [6:0] a, input int n, input logic [3:0][7:0] d);
        logic r, oe;
        int   oe_bad;
        oe_bad = 0;
        spi_cmd(a, 1'b0);
        for (int w = 0; w < n; w++)
            for (int j = DW - 1; j >= 0; j--) begin
                bit_xfer(d[w][j], r, oe);
                if (oe) oe_bad++;
            end
        spi_end();
        check("wr_oe_low", oe_bad, 0);
    endtask

    task automatic spi_read(input logic [6:0] a, input int n, output logic [3:0][7:0] q);
        logic r, oe;
        int   oe_bad;
        oe_bad = 0;
        q = '0;
        spi_cmd(a, 1'b1);
        for (int w = 0; w < n; w++)
            for (int j = DW - 1; j >= 0; j--) begin
                bit_xfer(1'b0, r, oe);
                if (!oe) oe_bad++;
                q[w][j] = r;
            end
        spi_end();
        check("rd_oe_high", oe_bad, 0);
        check("rd_end_idle", {30'd0, miso_oe, miso_pin}, 32'h0);
    endtask

    // Reference memory: word i of a burst lands at (base + i) mod 128.
    task automatic model_write(input logic [6:0] a, input int n, input logic [3:0][7:0] d, input bit blocked);
        for (int i = 0; i < n; i++) begin
            if (!blocked) begin
                model[(int'(a) + i) % 128] = d[i];
                known[(int'(a) + i) % 128] = 1'b1;
            end
        end
    endtask

    task automatic model_read_check(input string name, input logic [6:0] a, input int n);
        logic [3:0][7:0] q;
        spi_read(a, n, q);
        for (int i = 0; i < n; i++)
            if (known[(int'(a) + i) % 128])
                check(name, {24'd0, q[i]}, {24'd0, model[(int'(a) + i) % 128]});
    endtask

    initial begin
        vec_t            tbl[5];
        logic [3:0][7:0] q;
        logic [3:0][7:0] d;
        logic r, oe;
        logic [6:0] a;
        int n;

        for (int i = 0; i < 128; i++) begin
            model[i] = 8'h00;
            known[i] = 1'b0;
        end
`ifdef FAULT_INJECT_EN
        fault_blocks = 1'b1;
`else
        fault_blocks = 1'b0;
`endif

        tbl[0] = '{wr: 1'b1, addr: 7'h12, n: 1, dat: 32'h000000A5};
        tbl[1] = '{wr: 1'b0, addr: 7'h12, n: 1, dat: 32'h000000A5};
        tbl[2] = '{wr: 1'b1, addr: 7'h7F, n: 2, dat: 32'h00002211};
        tbl[3] = '{wr: 1'b0, addr: 7'h7F, n: 2, dat: 32'h00002211};
        tbl[4] = '{wr: 1'b0, addr: 7'h00, n: 1, dat: 32'h00000022};

        // Reset state
        clks(3);
        check("rst_leds", {28'd0, leds}, 32'h0);
        check("rst_miso", {30'd0, miso_oe, miso_pin}, 32'h0);
        rst_n = 1'b1;
        clks(10);

        for (int k = 0; k < 5; k++) begin
            if (tbl[k].wr) begin
                spi_write(tbl[k].addr, tbl[k].n, tbl[k].dat);
                model_write(tbl[k].addr, tbl[k].n, tbl[k].dat, 1'b0);
            end else begin
                spi_read(tbl[k].addr, tbl[k].n, q);
                for (int i = 0; i < tbl[k].n; i++)
                    check("tbl_rd", {24'd0, q[i]}, {24'd0, tbl[k].dat[i]});
            end
        end

        // Partial write word is dropped on cs rise
        d = 32'h0000003C;
        spi_write(7'h05, 1, d);
        model_write(7'h05, 1, d, 1'b0);
        spi_cmd(7'h05, 1'b0);
        for (int j = 0; j < 5; j++) bit_xfer(1'b1, r, oe);
        spi_end();
        check("abort_leds", {28'd0, leds}, 32'h0);
        spi_read(7'h05, 1, q);
        check("abort_mem", {24'd0, q[0]}, 32'h3C);

        // Reset mid-read, cs held low across release
        spi_cmd(7'h12, 1'b1);
        for (int j = 0; j < 3; j++) bit_xfer(1'b0, r, oe);
        check("mid_rd_state", {28'd0, leds}, 32'h3);
        rst_n = 1'b0;
        clks(1);
        rst_n = 1'b1;
        check("rst_mid_leds", {28'd0, leds}, 32'h0);
        check("rst_mid_oe", {31'd0, miso_oe}, 32'h0);
        for (int j = 0; j < 10; j++) bit_xfer(1'b1, r, oe);
        check("rst_no_frame", {28'd0, leds}, 32'h0);
        spi_end();
        spi_read(7'h12, 1, q);
        check("rst_mem_keep", {24'd0, q[0]}, 32'hA5);

        // sclk activity with cs high is ignored
        for (int j = 0; j < 16; j++) begin
            mosi_pin = 1'($urandom_range(0, 1));
            clks(HALF);
            sclk_pin = ~sclk_pin;
        end
        clks(HALF);
        check("cs_high_leds", {28'd0, leds}, 32'h0);
        model_read_check("cs_high_mem", 7'h12, 1);

        // Fault injection
        d = 32'h00000000;
        spi_write(7'h20, 1, d);
        model_write(7'h20, 1, d, 1'b0);
        fault_pin = 1'b1;
        clks(4);
        check("fault_led", {31'd0, leds[3]}, {31'd0, fault_blocks});
        d = 32'h000000FF;
        spi_write(7'h20, 1, d);
        model_write(7'h20, 1, d, fault_blocks);
        fault_pin = 1'b0;
        clks(4);
        model_read_check("fault_rd", 7'h20, 1);
        spi_write(7'h20, 1, d);
        model_write(7'h20, 1, d, 1'b0);
        model_read_check("nofault_rd", 7'h20, 1);

        // Randomised bursts against the reference memory
        for (int it = 0; it < 8; it++) begin
            a = 7'($urandom_range(0, 127));
            n = $urandom_range(1, 3);
            d = $urandom;
            spi_write(a, n, d);
            model_write(a, n, d, 1'b0);
            model_read_check("rand_rd", a, n);
            a = 7'($urandom_range(0, 127));
            for (int s = 0; s < 128 && !known[a]; s++) a = a + 7'd1;
            model_read_check("rand_rd_any", a, $urandom_range(1, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
